robs_mult_param: RTL and testbench

//  Parametrised sequential Robertson's multiplier. Next generation of the fixed 8-bit unit.
//  - Adds an operand width parameter, a per-operation signed/unsigned mode and a start/busy/done handshake.
//  - Sits between a requester (testbench or datapath controller) and a product consumer.
//  - Processes one multiplier bit per clock.

---
 rtl/robs_pkg.sv | 15 +
 rtl/robs_addsub.sv | 17 +
 rtl/robs_mult_param.sv | 115 +++++++++++
 tb/tb_robs_mult_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/robs_pkg.sv
// Shared types and constants for the Robertson's multiplier.
//   robs_state_t : FSM encoding (IDLE, RUN, DONE)
//   MODE_*       : value of the sampled mode_signed input
package robs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } robs_state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/robs_addsub.sv
// Combinational (W+1)-bit adder/subtractor for the accumulate step.
//   a   in  W+1  partial-product accumulator
//   b   in  W+1  extended multiplicand
//   sub in  1    1 = a - b, 0 = a + b
//   s   out W+1  result (modulo 2^(W+1))
module robs_addsub #(
  parameter int unsigned W = 8
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  input  logic       sub,
  output logic [W:0] s
);

  assign s = sub ? (a - b) : (a + b);

endmodule

// File: rtl/robs_mult_param.sv
// Sequential Robertson's multiplier, one multiplier bit per clock.
//   clk          in  1        rising-edge clock
//   reset        in  1        asynchronous active-low reset
//   start        in  1        sample operands and begin (accepted in IDLE or DONE)
//   mode_signed  in  1        1 = two's-complement operands; sampled with start
//   multiplier   in  WIDTH    operand Q
//   multiplicand in  WIDTH    operand M
//   product      out 2*WIDTH  result, held until the next completion
//   busy         out 1        high while iterating
//   done         out 1        one-cycle completion pulse
module robs_mult_param
  import robs_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode_signed,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  robs_state_t        r_state;
  robs_state_t        w_next_state;
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic [CW-1:0]      r_cnt;
  logic               r_mode;
  logic [2*WIDTH-1:0] r_product;

  logic               w_last;
  logic               w_sub;
  logic               w_fill;
  logic               w_load;
  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_s;
  logic [WIDTH:0]     w_a_next;
  logic [WIDTH-1:0]   w_q_next;

  // Datapath: one Robertson iteration on the current {A,Q}
  assign w_m_ext = (r_mode == MODE_SIGNED) ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
  assign w_last  = (r_cnt == LastCnt);
  // The multiplier MSB carries negative weight in two's complement, so the
  // last partial product is subtracted rather than added.
  assign w_sub   = w_last && (r_mode == MODE_SIGNED);

  robs_addsub #(
    .W (WIDTH)
  ) u_addsub (
    .a   (r_a),
    .b   (w_m_ext),
    .sub (w_sub),
    .s   (w_sum)
  );

  assign w_s      = r_q[0] ? w_sum : r_a;
  assign w_fill   = (r_mode == MODE_SIGNED) ? w_s[WIDTH] : 1'b0;
  assign w_a_next = {w_fill, w_s[WIDTH:1]};
  assign w_q_next = {w_s[0], r_q[WIDTH-1:1]};

  assign w_load = start && ((r_state == IDLE) || (r_state == DONE));

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? RUN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_mode    <= MODE_UNSIGNED;
      r_product <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_a    <= '0;
        r_q    <= multiplier;
        r_m    <= multiplicand;
        r_cnt  <= '0;
        r_mode <= mode_signed;
      end else if (r_state == RUN) begin
        r_a   <= w_a_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_product <= {w_a_next[WIDTH-1:0], w_q_next};
        end
      end
    end
  end

  assign product = r_product;
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_robs_mult_param.sv
// Directed and random checks of robs_mult_param at WIDTH=8 and WIDTH=16.
module tb_robs_mult_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, mode8, busy8, done8;
  logic [7:0]  q8, m8;
  logic [15:0] p8;
  logic        start16, mode16, busy16, done16;
  logic [15:0] q16, m16;
  logic [31:0] p16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  robs_mult_param #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .reset        (reset),
    .start        (start8),
    .mode_signed  (mode8),
    .multiplier   (q8),
    .multiplicand (m8),
    .product      (p8),
    .busy         (busy8),
    .done         (done8)
  );

  robs_mult_param #(.WIDTH(16)) u_dut16 (
    .clk          (clk),
    .reset        (reset),
    .start        (start16),
    .mode_signed  (mode16),
    .multiplier   (q16),
    .multiplicand (m16),
    .product      (p16),
    .busy         (busy16),
    .done         (done16)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer multiply as the reference
  function automatic logic [31:0] model(input bit wide, input bit sgn,
                                        input logic [15:0] q, input logic [15:0] m);
    logic signed [33:0] a, b;
    logic [33:0] r;
    logic [7:0] q_lo, m_lo;
    q_lo = q[7:0];
    m_lo = m[7:0];
    if (wide) begin
      a = sgn ? 34'($signed(q)) : {18'b0, q};
      b = sgn ? 34'($signed(m)) : {18'b0, m};
    end else begin
      a = sgn ? 34'($signed(q_lo)) : {26'b0, q_lo};
      b = sgn ? 34'($signed(m_lo)) : {26'b0, m_lo};
    end
    r = a * b;
    return wide ? r[31:0] : {16'h0, r[15:0]};
  endfunction

  function automatic logic cur_done(input bit wide);
    return wide ? done16 : done8;
  endfunction

  function automatic logic cur_busy(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic [31:0] cur_prod(input bit wide);
    return wide ? p16 : {16'h0, p8};
  endfunction

  task automatic drive(input bit wide, input bit st, input bit sgn,
                       input logic [15:0] q, input logic [15:0] m);
    if (wide) begin
      start16 = st; mode16 = sgn; q16 = q; m16 = m;
    end else begin
      start8 = st; mode8 = sgn; q8 = q[7:0]; m8 = m[7:0];
    end
  endtask

  task automatic drive_start(input bit wide, input bit st);
    if (wide) start16 = st;
    else start8 = st;
  endtask

  // Issue one op and follow it to done. b2b=1: caller is already at the
  // negedge of a DONE cycle. repulse_at>=0: pulse start with other operands
  // and the opposite mode at that many edges into RUN.
  task automatic run_op(input string tag, input bit wide, input bit sgn,
                        input logic [15:0] q, input logic [15:0] m,
                        input bit b2b, input int repulse_at,
                        output logic [31:0] prod, output int lat, output int bcnt);
    logic [31:0] prev;
    bit got;
    if (!b2b) @(negedge clk);
    prev = cur_prod(wide);
    drive(wide, 1'b1, sgn, q, m);
    @(posedge clk);
    @(negedge clk);
    drive_start(wide, 1'b0);
    lat  = 0;
    bcnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (cur_done(wide)) begin
        got = 1'b1;
        break;
      end
      if (cur_busy(wide)) bcnt++;
      check_val({tag, "_hold"}, cur_prod(wide), prev);
      if (lat == repulse_at) drive(wide, 1'b1, ~sgn, ~q, m + 16'd1);
      else drive_start(wide, 1'b0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    drive_start(wide, 1'b0);
    if (!got) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    check_val({tag, "_excl"}, 32'(cur_busy(wide) & cur_done(wide)), 32'd0);
    prod = cur_prod(wide);
  endtask

  task automatic full_op(input string tag, input bit wide, input bit sgn,
                         input logic [15:0] q, input logic [15:0] m);
    logic [31:0] prod;
    int lat, bcnt;
    run_op(tag, wide, sgn, q, m, 1'b0, -1, prod, lat, bcnt);
    check_val(tag, prod, model(wide, sgn, q, m));
  endtask

  initial begin
    logic [31:0] prod;
    int lat, bcnt, seen;

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check_val("rst_p8", {16'h0, p8}, 32'h0);
    check_val("rst_busy8", 32'(busy8), 32'h0);
    check_val("rst_done8", 32'(done8), 32'h0);
    check_val("rst_p16", p16, 32'h0);
    reset = 1'b1;

    // 1: unsigned 255*255, done WIDTH edges after the start edge
    run_op("u_ff_ff", 1'b0, 1'b0, 16'hFF, 16'hFF, 1'b0, -1, prod, lat, bcnt);
    check_val("u_ff_ff", prod, 32'hFE01);
    check_val("u_ff_ff_lat", 32'(lat), 32'd8);
    check_val("u_ff_ff_busy", 32'(bcnt), 32'd8);
    @(negedge clk);
    check_val("done_pulse", 32'(done8), 32'd0);

    // 2: signed corner cases
    run_op("s_m128sq", 1'b0, 1'b1, 16'h80, 16'h80, 1'b0, -1, prod, lat, bcnt);
    check_val("s_m128sq", prod, 32'h4000);
    run_op("s_m1x127", 1'b0, 1'b1, 16'hFF, 16'h7F, 1'b0, -1, prod, lat, bcnt);
    check_val("s_m1x127", prod, 32'hFF81);

    // 3: zero operands
    run_op("s_0xm5", 1'b0, 1'b1, 16'h00, 16'hFB, 1'b0, -1, prod, lat, bcnt);
    check_val("s_0xm5", prod, 32'h0);
    check_val("s_0xm5_busy", 32'(bcnt), 32'd8);
    run_op("u_ffx0", 1'b0, 1'b0, 16'hFF, 16'h00, 1'b0, -1, prod, lat, bcnt);
    check_val("u_ffx0", prod, 32'h0);
    @(negedge clk);
    check_val("u_ffx0_pulse", 32'(done8), 32'd0);

    // 4: start during RUN ignored; start in DONE accepted back-to-back
    run_op("repulse", 1'b0, 1'b0, 16'h12, 16'h34, 1'b0, 3, prod, lat, bcnt);
    check_val("repulse", prod, 32'h03A8);
    check_val("repulse_lat", 32'(lat), 32'd8);
    run_op("b2b", 1'b0, 1'b1, 16'hF6, 16'h07, 1'b1, -1, prod, lat, bcnt);
    check_val("b2b", prod, 32'hFFBA);
    check_val("b2b_lat", 32'(lat), 32'd8);

    // 5: reset at iteration 4 aborts the op
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h09, 16'h0B);
    @(posedge clk);
    @(negedge clk);
    drive_start(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("abort_p8", {16'h0, p8}, 32'h0);
    check_val("abort_busy", 32'(busy8), 32'h0);
    check_val("abort_done", 32'(done8), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    check_val("abort_quiet", 32'(seen), 32'd0);
    run_op("u_3x5", 1'b0, 1'b0, 16'h03, 16'h05, 1'b0, -1, prod, lat, bcnt);
    check_val("u_3x5", prod, 32'h000F);

    // 6: 16-bit instance
    run_op("s16_corner", 1'b1, 1'b1, 16'h8000, 16'h7FFF, 1'b0, -1, prod, lat, bcnt);
    check_val("s16_corner", prod, 32'hC0008000);
    check_val("s16_lat", 32'(lat), 32'd16);
    check_val("s16_busy", 32'(bcnt), 32'd16);
    full_op("u16_ones", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    full_op("s16_ones", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      full_op("r16", 1'b1, 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      full_op("r8", 1'b0, 1'($urandom_range(1)), 16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
